// File: rtl/ps2_pkg.sv
// Scan-code constants, key bit positions and FSM state type shared by the
// PS/2 key decoder and its keymap.
package ps2_pkg;

    localparam int NUM_KEYS = 6;

    localparam logic [7:0] SC_ERR   = 8'h00;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_ACK   = 8'hFA;
    localparam logic [7:0] SC_BAT   = 8'hAA;
    localparam logic [7:0] SC_ECHO  = 8'hEE;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ESC   = 8'h76;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_SPACE = 4;
    localparam int KEY_ESC   = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_e;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte-in / key-event-out bundle between a PS/2 receiver (master) and the
// key decoder (slave).
interface ps2_key_decoder_if;
    import ps2_pkg::*;

    logic                CODE_VALID;
    logic [7:0]          CODEWORD;
    logic [NUM_KEYS-1:0] KEY_STATE;
    logic [NUM_KEYS-1:0] KEY_PRESS;
    logic [NUM_KEYS-1:0] KEY_RELEASE;
    logic                DEC_ERR;

    modport master (
        output CODE_VALID, CODEWORD,
        input  KEY_STATE, KEY_PRESS, KEY_RELEASE, DEC_ERR
    );

    modport slave (
        input  CODE_VALID, CODEWORD,
        output KEY_STATE, KEY_PRESS, KEY_RELEASE, DEC_ERR
    );
endinterface

// File: rtl/ps2_keymap.sv
// Combinational scan-byte to key one-hot lookup; arrows only exist in the
// extended set, space/esc only in the plain set, so keypad codes map to nothing.
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic [7:0]          code,
    input  logic                ext,
    output logic [NUM_KEYS-1:0] key_mask
);

    always_comb begin
        key_mask = '0;
        if (ext) begin
            case (code)
                SC_UP:    key_mask[KEY_UP]    = 1'b1;
                SC_DOWN:  key_mask[KEY_DOWN]  = 1'b1;
                SC_LEFT:  key_mask[KEY_LEFT]  = 1'b1;
                SC_RIGHT: key_mask[KEY_RIGHT] = 1'b1;
                default:  key_mask = '0;
            endcase
        end else begin
            case (code)
                SC_SPACE: key_mask[KEY_SPACE] = 1'b1;
                SC_ESC:   key_mask[KEY_ESC]   = 1'b1;
                default:  key_mask = '0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan byte decoder: tracks E0/F0 prefixes, maintains a held-key
// bitmap and emits registered press/release/error pulses.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 1000000
) (
    input  logic             CLK,
    input  logic             RESET,
    ps2_key_decoder_if.slave bus
);

    localparam int CW = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PREFIX_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] key_state_q, key_state_d;
    logic [NUM_KEYS-1:0] key_press_q, key_press_d;
    logic [NUM_KEYS-1:0] key_release_q, key_release_d;
    logic                dec_err_q, dec_err_d;

    logic                is_ext;
    logic                is_brk;
    logic [NUM_KEYS-1:0] key_mask;

    assign is_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign is_brk = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

    ps2_keymap u_keymap (
        .code     (bus.CODEWORD),
        .ext      (is_ext),
        .key_mask (key_mask)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            key_state_q   <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
            dec_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_state_q   <= key_state_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            dec_err_q     <= dec_err_d;
        end
    end

    // A received byte always wins over a timeout expiring in the same cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        dec_err_d   = 1'b0;

        if (bus.CODE_VALID) begin
            cnt_d = '0;
            case (bus.CODEWORD)
                SC_ERR: begin
                    state_d   = ST_IDLE;
                    dec_err_d = 1'b1;
                end
                SC_ACK, SC_BAT, SC_ECHO: begin
                    state_d = state_q;
                end
                SC_EXT: state_d = ST_EXT;
                SC_BRK: state_d = is_ext ? ST_EXT_BRK : ST_BRK;
                default: begin
                    state_d     = ST_IDLE;
                    key_state_d = is_brk ? (key_state_q & ~key_mask)
                                         : (key_state_q | key_mask);
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                dec_err_d = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end

        // Edges of the bitmap, so typematic repeats and stray breaks stay silent.
        key_press_d   = key_state_d & ~key_state_q;
        key_release_d = key_state_q & ~key_state_d;
    end

    assign bus.KEY_STATE   = key_state_q;
    assign bus.KEY_PRESS   = key_press_q;
    assign bus.KEY_RELEASE = key_release_q;
    assign bus.DEC_ERR     = dec_err_q;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter: PREFIX_TIMEOUT, default 1000000, CLK cycles a pending E0/F0 prefix may wait before being discarded.
REQ-002 Port: CLK  input  1  board clock, the only clock; all logic on posedge CLK.
REQ-003 Port: RESET  input  1  reset, asynchronous and active-high.
REQ-004 Port: CODE_VALID  input  1  one-cycle strobe; a received 8-bit scan byte is present on CODEWORD.
REQ-005 Port: CODEWORD  input  8  scan byte; sampled only when CODE_VALID=1.
REQ-006 Port: KEY_STATE  output  6  held-key bitmap; [0]=up, [1]=down, [2]=left, [3]=right, [4]=space, [5]=esc.
REQ-007 Port: KEY_PRESS  output  6  one-cycle pulse per bit on a 0->1 transition of KEY_STATE.
REQ-008 Port: KEY_RELEASE  output  6  one-cycle pulse per bit on a 1->0 transition of KEY_STATE.
REQ-009 Port: DEC_ERR  output  1  one-cycle pulse when a byte of 8'h00 arrives (upstream parity/framing error) or a prefix times out.

Function
REQ-010 The FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-011 IDLE: E0->EXT; F0->BRK; other byte->non-extended make decode, stay IDLE.
REQ-012 EXT: F0->EXT_BRK; E0->EXT; other->extended make decode, ->IDLE.
REQ-013 BRK: F0->BRK; E0->EXT; other->non-extended break decode, ->IDLE.
REQ-014 EXT_BRK: F0->EXT_BRK; E0->EXT; other->extended break decode, ->IDLE.
REQ-015 Extended map SHALL be 75=up, 72=down, 6B=left, 74=right; non-extended map 29=space, 76=esc; all other codes SHALL decode to no key and change no output.
REQ-016 Non-extended 75/72/6B/74 (keypad) SHALL NOT affect arrow bits; extended 29/76 SHALL NOT affect space/esc.
REQ-017 Make sets the mapped KEY_STATE bit; break clears it.
REQ-018 A make for an already-held key (typematic repeat) SHALL leave KEY_STATE unchanged with no KEY_PRESS pulse; a break for an unheld key SHALL produce no KEY_RELEASE pulse.
REQ-019 Bytes 8'hFA, 8'hAA, 8'hEE SHALL be ignored in any state and SHALL NOT change state.
REQ-020 Byte 8'h00 with CODE_VALID SHALL force IDLE and pulse DEC_ERR; KEY_STATE unchanged.
REQ-021 Latency: KEY_STATE, KEY_PRESS, KEY_RELEASE, DEC_ERR SHALL update on the first posedge after the CODE_VALID cycle (all outputs registered).
REQ-022 A timeout counter SHALL run only in EXT, BRK or EXT_BRK, clear on every CODE_VALID, and on reaching PREFIX_TIMEOUT-1 force IDLE and pulse DEC_ERR.
REQ-023 If CODE_VALID coincides with timeout expiry, the byte SHALL be processed from the current state and the timeout ignored.
REQ-024 Counter width SHALL be $clog2(PREFIX_TIMEOUT+1); the counter SHALL saturate and never wrap.
REQ-025 CODE_VALID on consecutive cycles SHALL be accepted, one byte per cycle.

Reset
REQ-026 RESET=1 SHALL asynchronously force IDLE, counter 0, KEY_STATE=0, KEY_PRESS=0, KEY_RELEASE=0, DEC_ERR=0.
REQ-027 RESET asserted mid-sequence (after E0 or F0) SHALL discard the prefix; the next byte after release is decoded from IDLE.
REQ-028 No outputs SHALL pulse on the first cycle after RESET deasserts.

Structure
REQ-029 Package ps2_pkg SHALL hold scan constants (E0, F0, FA, AA, EE, 75, 72, 6B, 74, 29, 76), KEY_STATE bit indices and the FSM state typedef.
REQ-030 Sub-module ps2_keymap (combinational: byte + extended flag -> 6-bit one-hot or zero) SHALL implement REQ-015/016.

Verification
REQ-031 Bytes E0,75 -> KEY_STATE=6'b000001, KEY_PRESS[0] pulses once; then E0,F0,75 -> KEY_STATE=0, KEY_RELEASE[0] pulses.
REQ-032 Bytes 29,29,29 then F0,29 -> one KEY_PRESS[4] pulse only; one KEY_RELEASE[4] pulse; KEY_STATE[4] 1 then 0.
REQ-033 Byte 75 without E0 -> no output change; bytes E0,76 -> no output change.
REQ-034 Byte E0 then idle PREFIX_TIMEOUT cycles -> DEC_ERR pulse, state IDLE; then byte 72 -> no change (non-extended).
REQ-035 Byte E0, RESET pulse, byte 74 -> KEY_STATE stays 0; byte 00 in BRK -> DEC_ERR pulse, next F0,76 releases nothing.
REQ-036 Back-to-back CODE_VALID E0,6B,E0,74 -> KEY_STATE=6'b001100, two KEY_PRESS pulses on successive decode cycles.
